// File: rtl/hpram_cmd_arbiter_pkg.sv
// Shared types and constants for the HyperRAM command arbiter.
// Holds the FSM state encoding, the command-bit encoding and a width helper.
// Combinational only; nothing here carries state or flow control.
package hpram_cmd_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WR_BURST = 2'd1,
    ST_RD_WAIT  = 2'd2,
    ST_GAP      = 2'd3
  } arb_state_t;

  localparam logic CMD_WR = 1'b1;
  localparam logic CMD_RD = 1'b0;

  // Ceiling log2, never below 1 so a derived counter always has a bit.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/hpram_arb_rr2.sv
// Two-way round-robin picker; requester 1 may be forced to win by urgent_i.
// Latency: purely combinational, grant valid in the same cycle as req_i.
// Backpressure: none; the caller decides when a grant is actually taken.
module hpram_arb_rr2
  import hpram_cmd_arbiter_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       urgent_i,
  input  logic       last_i,
  output logic [1:0] grant_o
);

  // Urgent override first, then alternate on a tie, else the lone requester.
  always_comb begin
    grant_o = 2'b00;
    if (req_i[1] && urgent_i) begin
      grant_o = 2'b10;
    end else if (&req_i) begin
      grant_o = last_i ? 2'b01 : 2'b10;
    end else begin
      grant_o = req_i;
    end
  end

endmodule

// File: rtl/hpram_cmd_arbiter.sv
// Shares the HyperRAM command port between the video write and read channels.
// Latency: grant, O_cmd_en and ack appear one cycle after arbitration in IDLE.
// Backpressure: requests hold until acked; bursts are fixed length, then a gap.
// Optional grant statistics ports are built when HPRAM_ARB_STATS_EN is defined.
module hpram_cmd_arbiter
  import hpram_cmd_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 22,
  parameter int DATA_W      = 32,
  parameter int BURST_BEATS = 16,
  parameter int CMD_GAP     = 4,
  parameter int RD_TIMEOUT  = 255
) (
  input  logic                I_dma_clk,
  input  logic                I_rst_n,
  input  logic                I_init_calib,
  input  logic                I_wr_req,
  input  logic [ADDR_W-1:0]   I_wr_addr,
  input  logic [DATA_W-1:0]   I_wr_data,
  input  logic [DATA_W/8-1:0] I_wr_mask,
  output logic                O_wr_ack,
  output logic                O_wr_data_re,
  input  logic                I_rd_req,
  input  logic [ADDR_W-1:0]   I_rd_addr,
  input  logic                I_rd_urgent,
  output logic                O_rd_ack,
  output logic                O_rd_data_valid,
  output logic [DATA_W-1:0]   O_rd_data,
  output logic                O_cmd,
  output logic                O_cmd_en,
  output logic [ADDR_W-1:0]   O_addr,
  output logic [DATA_W-1:0]   O_wr_data,
  output logic [DATA_W/8-1:0] O_data_mask,
  input  logic                I_rd_data_valid,
  input  logic [DATA_W-1:0]   I_rd_data,
  output logic                O_busy,
`ifdef HPRAM_ARB_STATS_EN
  output logic [15:0]         O_wr_grants,
  output logic [15:0]         O_rd_grants,
  output logic [15:0]         O_urgent_grants,
`endif
  output logic                O_rd_timeout
);

  localparam int BEAT_W = clog2(BURST_BEATS);
  localparam int TMO_W  = clog2(RD_TIMEOUT + 1);
  localparam int GAP_W  = clog2(CMD_GAP + 1);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_BEATS - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(RD_TIMEOUT);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((CMD_GAP > 0) ? CMD_GAP - 1 : 0);
  // With no gap configured a finished burst drops straight back to IDLE.
  localparam logic GAP_EN = (CMD_GAP > 0);

  arb_state_t          state_q;
  logic [BEAT_W-1:0]   beat_q;
  logic [TMO_W-1:0]    tmo_q;
  logic [GAP_W-1:0]    gap_q;
  logic                last_rd_q;
  logic                cmd_en_q, cmd_q, wr_ack_q, rd_ack_q, wr_re_q, busy_q, tmo_flag_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [1:0]          grant;
  logic                arb_ok, wr_grant, rd_grant;

  hpram_arb_rr2 u_rr2 (
    .req_i    ({I_rd_req, I_wr_req}),
    .urgent_i (I_rd_urgent),
    .last_i   (last_rd_q),
    .grant_o  (grant)
  );

  assign arb_ok   = (state_q == ST_IDLE) && I_init_calib;
  assign wr_grant = arb_ok && grant[0];
  assign rd_grant = arb_ok && grant[1];

  // Main FSM: arbitration, burst beat counting, read timeout and command gap.
  always_ff @(posedge I_dma_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q    <= ST_IDLE;
      beat_q     <= '0;
      tmo_q      <= '0;
      gap_q      <= '0;
      last_rd_q  <= 1'b1;
      cmd_en_q   <= 1'b0;
      cmd_q      <= 1'b0;
      addr_q     <= '0;
      wr_ack_q   <= 1'b0;
      rd_ack_q   <= 1'b0;
      wr_re_q    <= 1'b0;
      busy_q     <= 1'b0;
      tmo_flag_q <= 1'b0;
    end else begin
      cmd_en_q <= 1'b0;
      wr_ack_q <= 1'b0;
      rd_ack_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (wr_grant) begin
            cmd_en_q  <= 1'b1;
            cmd_q     <= CMD_WR;
            addr_q    <= I_wr_addr;
            wr_ack_q  <= 1'b1;
            wr_re_q   <= 1'b1;
            busy_q    <= 1'b1;
            last_rd_q <= 1'b0;
            beat_q    <= '0;
            state_q   <= ST_WR_BURST;
          end else if (rd_grant) begin
            cmd_en_q  <= 1'b1;
            cmd_q     <= CMD_RD;
            addr_q    <= I_rd_addr;
            rd_ack_q  <= 1'b1;
            busy_q    <= 1'b1;
            last_rd_q <= 1'b1;
            beat_q    <= '0;
            tmo_q     <= '0;
            state_q   <= ST_RD_WAIT;
          end
        end
        ST_WR_BURST: begin
          if (beat_q == BEAT_LAST) begin
            beat_q  <= '0;
            wr_re_q <= 1'b0;
            busy_q  <= GAP_EN;
            state_q <= GAP_EN ? ST_GAP : ST_IDLE;
          end else begin
            beat_q <= beat_q + 1'b1;
          end
        end
        ST_RD_WAIT: begin
          // A final beat landing on the timeout cycle still counts as success.
          if (I_rd_data_valid && (beat_q == BEAT_LAST)) begin
            beat_q  <= '0;
            tmo_q   <= '0;
            busy_q  <= GAP_EN;
            state_q <= GAP_EN ? ST_GAP : ST_IDLE;
          end else if (tmo_q == TMO_LAST) begin
            tmo_flag_q <= 1'b1;
            beat_q     <= '0;
            tmo_q      <= '0;
            busy_q     <= GAP_EN;
            state_q    <= GAP_EN ? ST_GAP : ST_IDLE;
          end else begin
            tmo_q <= tmo_q + 1'b1;
            if (I_rd_data_valid) beat_q <= beat_q + 1'b1;
          end
        end
        ST_GAP: begin
          if (gap_q == GAP_LAST) begin
            gap_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef HPRAM_ARB_STATS_EN
  logic [15:0] wr_grants_q, rd_grants_q, urg_grants_q;

  // Saturating grant counters for bandwidth debugging.
  always_ff @(posedge I_dma_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      wr_grants_q  <= '0;
      rd_grants_q  <= '0;
      urg_grants_q <= '0;
    end else begin
      if (wr_grant && (wr_grants_q != 16'hFFFF)) wr_grants_q <= wr_grants_q + 1'b1;
      if (rd_grant && (rd_grants_q != 16'hFFFF)) rd_grants_q <= rd_grants_q + 1'b1;
      if (rd_grant && I_rd_urgent && (urg_grants_q != 16'hFFFF)) urg_grants_q <= urg_grants_q + 1'b1;
    end
  end

  assign O_wr_grants     = wr_grants_q;
  assign O_rd_grants     = rd_grants_q;
  assign O_urgent_grants = urg_grants_q;
`endif

  assign O_cmd_en        = cmd_en_q;
  assign O_cmd           = cmd_q;
  assign O_addr          = addr_q;
  assign O_wr_ack        = wr_ack_q;
  assign O_rd_ack        = rd_ack_q;
  assign O_wr_data_re    = wr_re_q;
  assign O_busy          = busy_q;
  assign O_rd_timeout    = tmo_flag_q;
  // Write beats only reach the memory pins while a write burst is running.
  assign O_wr_data       = (state_q == ST_WR_BURST) ? I_wr_data : '0;
  assign O_data_mask     = (state_q == ST_WR_BURST) ? I_wr_mask : '0;
  // Read beats outside an outstanding read are discarded.
  assign O_rd_data_valid = (state_q == ST_RD_WAIT) && I_rd_data_valid;
  assign O_rd_data       = I_rd_data;

endmodule
